// File: rtl/nr_pkg.sv
// Shared constants for the noise-reduction datapath: pixel width and
// 3x3 window indexing used by the window generator and abs-diff array.
package nr_pkg;

  localparam int PIX_W = 8;
  localparam int WIN_C = 4;
  localparam int WIN_N = 9;
  localparam int NB_N  = 8;

  // Neighbour positions of the window (all but the centre), in index order.
  localparam logic [3:0] NB_IDX [NB_N] = '{4'd0, 4'd1, 4'd2, 4'd3,
                                           4'd5, 4'd6, 4'd7, 4'd8};

endpackage : nr_pkg

// File: rtl/line_buffer.sv
// One-line pixel store with a single shared read/write address.
// The read is combinational and returns the contents before this cycle's
// write lands, so a column can be read and overwritten in the same cycle.
// Storage is deliberately not reset; row/column gating upstream hides it.
module line_buffer #(
  parameter  int DEPTH = 640,
  parameter  int WIDTH = 8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write port: store the incoming pixel at the current column.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule : line_buffer

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator. Buffers the two previous lines,
// shifts a 3x3 register on every accepted pixel and flags windows that
// lie entirely inside the image (no border padding).
module window_3x3_gen
  import nr_pkg::*;
#(
  parameter int IMG_WIDTH = 640,
  parameter int DATA_W    = PIX_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     pix_in,
  input  logic                  pix_valid,
  input  logic                  sof,
  output logic [9*DATA_W-1:0]   win,
  output logic                  win_valid
);

  localparam int             CW       = $clog2(IMG_WIDTH);
  localparam logic [CW-1:0]  COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0]  COL_TWO  = CW'(2);

  logic [CW-1:0]     r_col;
  logic [1:0]        r_row;
  logic [CW-1:0]     w_col;
  logic [1:0]        w_row;
  logic              w_wrap;
  logic              w_win_hit;
  logic [DATA_W-1:0] w_top;
  logic [DATA_W-1:0] w_mid;
  logic [DATA_W-1:0] r_win [WIN_N];
  logic              r_win_valid;

  // Position of the pixel on the input this cycle; a qualified sof overrides
  // whatever the counters hold and pins it to (0,0).
  always_comb begin
    w_col = r_col;
    w_row = r_row;
    if (pix_valid && sof) begin
      w_col = '0;
      w_row = 2'd0;
    end else begin
      w_col = r_col;
      w_row = r_row;
    end
    w_wrap    = (w_col == COL_LAST);
    w_win_hit = pix_valid && (w_row == 2'd2) && (w_col >= COL_TWO);
  end

  // Column/row counters; row saturates at 2 since only "at least two lines
  // buffered" matters for validity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= 2'd0;
    end else if (pix_valid) begin
      if (w_wrap) begin
        r_col <= '0;
        r_row <= (w_row == 2'd2) ? w_row : (w_row + 2'd1);
      end else begin
        r_col <= w_col + CW'(1);
        r_row <= w_row;
      end
    end
  end

  // lb0 holds the previous line, lb1 the line before; lb1 is fed from lb0's
  // old value so the pair forms a two-line cascade.
  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_W)) u_lb0 (
    .clk     (clk),
    .i_we    (pix_valid),
    .i_addr  (w_col),
    .i_wdata (pix_in),
    .o_rdata (w_mid)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_W)) u_lb1 (
    .clk     (clk),
    .i_we    (pix_valid),
    .i_addr  (w_col),
    .i_wdata (w_mid),
    .o_rdata (w_top)
  );

  // Window shift register: each row moves left, right column takes
  // top tap / middle tap / new pixel. Holds through stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < WIN_N; k++) begin
        r_win[k] <= '0;
      end
    end else if (pix_valid) begin
      for (int dy = 0; dy < 3; dy++) begin
        r_win[3*dy]     <= r_win[3*dy + 1];
        r_win[3*dy + 1] <= r_win[3*dy + 2];
      end
      r_win[2] <= w_top;
      r_win[5] <= w_mid;
      r_win[8] <= pix_in;
    end
  end

  // Window-valid flag for the pixel just accepted; low on stalled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_valid <= 1'b0;
    end else begin
      r_win_valid <= w_win_hit;
    end
  end

  for (genvar k = 0; k < WIN_N; k++) begin : g_pack
    assign win[DATA_W*k +: DATA_W] = r_win[k];
  end

  assign win_valid = r_win_valid;

endmodule : window_3x3_gen

// File: tb/tb_window_3x3_gen.sv
// Scoreboard bench for window_3x3_gen with a small image-array reference.
module tb_window_3x3_gen;

  localparam int W  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] pix_in = '0;
  logic          pix_valid = 1'b0;
  logic          sof = 1'b0;
  logic [9*DW-1:0] win;
  logic          win_valid;

  always #5 clk = ~clk;

  window_3x3_gen #(.IMG_WIDTH(W), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .sof       (sof),
    .win       (win),
    .win_valid (win_valid)
  );

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic last_pv = 1'b0;
  logic [9*DW-1:0] exp_q [$];
  logic [9*DW-1:0] seen_q [$];
  logic [9*DW-1:0] t1_q [$];
  logic [9*DW-1:0] exp_w;

  // Reference image: rows kept modulo 4, true row index unbounded.
  logic [DW-1:0] img [4][W];
  int mr = 0;
  int mc = 0;

  localparam logic [9*DW-1:0] FIRST_WIN =
    {8'h22, 8'h21, 8'h20, 8'h12, 8'h11, 8'h10, 8'h02, 8'h01, 8'h00};

  task automatic cyc(input logic pv, input logic s, input logic [DW-1:0] d);
    logic [9*DW-1:0] w;
    pix_valid = pv;
    sof       = s;
    pix_in    = d;
    if (pv) begin
      if (s) begin
        mr = 0;
        mc = 0;
      end
      img[mr % 4][mc] = d;
      if (mr >= 2 && mc >= 2) begin
        for (int dy = 0; dy < 3; dy++)
          for (int dx = 0; dx < 3; dx++)
            w[DW*(3*dy+dx) +: DW] = img[(mr - 2 + dy) % 4][mc - 2 + dx];
        exp_q.push_back(w);
      end
      mc++;
      if (mc == W) begin
        mc = 0;
        if (mr < 1000) mr++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string name, input logic [9*DW-1:0] act,
                          input logic [9*DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  // Pattern frame: pixel = 16*row + col; optional stall every other cycle
  // and a 5-cycle gap after row 1.
  task automatic frame(input bit use_sof, input int rows, input bit stall);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < W; c++) begin
        if (stall) cyc(1'b0, 1'b0, 8'hEE);
        cyc(1'b1, (use_sof && r == 0 && c == 0), 8'(16*r + c));
      end
      if (stall && r == 1) repeat (5) cyc(1'b0, 1'b0, 8'hEE);
    end
  endtask

  task automatic drain(input string name);
    repeat (4) cyc(1'b0, 1'b0, 8'h00);
    check_int(name, exp_q.size(), 0);
  endtask

  // Record whether a pixel was offered at each active edge.
  always @(posedge clk) last_pv <= pix_valid;

  // Monitor: pops expected windows whenever the DUT flags one.
  always @(negedge clk) begin
    if (!last_pv) begin
      checks++;
      if (win_valid !== 1'b0) begin
        errors++;
        $display("FAIL stall_valid: actual %b required 0", win_valid);
      end
    end
    if (win_valid === 1'b1) begin
      pulses++;
      seen_q.push_back(win);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_window: actual %h required none", win);
      end else begin
        exp_w = exp_q.pop_front();
        if (win !== exp_w) begin
          errors++;
          $display("FAIL window: actual %h required %h", win, exp_w);
        end
      end
    end
  end

  initial begin
    int p0;
    repeat (2) @(posedge clk);
    check_eq("reset_win", win, '0);
    check_int("reset_valid", int'(win_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: continuous 4x4 frame.
    seen_q.delete(); p0 = pulses;
    frame(1'b1, 4, 1'b0);
    drain("t1_drain");
    check_int("t1_pulses", pulses - p0, 4);
    if (seen_q.size() > 0) begin
      check_eq("t1_first", seen_q[0], FIRST_WIN);
      check_int("t1_centre", int'(seen_q[0][DW*4 +: DW]), 8'h11);
    end else check_int("t1_seen", seen_q.size(), 4);
    t1_q = seen_q;

    // Test 2: same frame with stalls.
    seen_q.delete(); p0 = pulses;
    frame(1'b1, 4, 1'b1);
    drain("t2_drain");
    check_int("t2_pulses", pulses - p0, 4);
    for (int i = 0; i < 4; i++)
      if (i < seen_q.size() && i < t1_q.size()) check_eq("t2_seq", seen_q[i], t1_q[i]);

    // Test 3: frame abandoned after 2 pixels of row 3, then a new frame.
    seen_q.delete(); p0 = pulses;
    frame(1'b1, 3, 1'b0);
    cyc(1'b1, 1'b0, 8'h30);
    cyc(1'b1, 1'b0, 8'h31);
    frame(1'b1, 4, 1'b0);
    drain("t3_drain");
    check_int("t3_pulses", pulses - p0, 6);
    if (seen_q.size() > 2) check_eq("t3_second_first", seen_q[2], FIRST_WIN);
    else check_int("t3_seen", seen_q.size(), 6);

    // Test 4: asynchronous reset mid-row 2, then frame without sof.
    frame(1'b1, 2, 1'b0);
    cyc(1'b1, 1'b0, 8'h20);
    cyc(1'b1, 1'b0, 8'h21);
    #2;
    rst_n = 1'b0;
    pix_valid = 1'b0;
    sof = 1'b0;
    #1;
    check_eq("t4_rst_win", win, '0);
    check_int("t4_rst_valid", int'(win_valid), 0);
    exp_q.delete();
    mr = 0; mc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    seen_q.delete(); p0 = pulses;
    frame(1'b0, 4, 1'b0);
    drain("t4_drain");
    check_int("t4_pulses", pulses - p0, 4);
    for (int i = 0; i < 4; i++)
      if (i < seen_q.size()) check_eq("t4_seq", seen_q[i], t1_q[i]);

    // Test 5: sof without valid is ignored; sof on the wrap cycle restarts.
    seen_q.delete(); p0 = pulses;
    frame(1'b1, 2, 1'b0);
    for (int c = 0; c < 3; c++) cyc(1'b1, 1'b0, 8'(32 + c));
    cyc(1'b0, 1'b1, 8'h99);
    cyc(1'b1, 1'b0, 8'h23);
    for (int c = 0; c < 3; c++) cyc(1'b1, 1'b0, 8'(48 + c));
    frame(1'b1, 4, 1'b0);
    drain("t5_drain");
    check_int("t5_pulses", pulses - p0, 7);
    if (seen_q.size() > 3) check_eq("t5_restart_first", seen_q[3], FIRST_WIN);

    // Random frames with stalls, stray sof, partial lines.
    for (int f = 0; f < 30; f++) begin
      int npix;
      bit use_sof;
      use_sof = ($urandom_range(0, 3) != 0);
      npix = $urandom_range(1, 6) * W;
      if ($urandom_range(0, 2) == 0) npix = npix - $urandom_range(0, W - 1);
      for (int i = 0; i < npix; i++) begin
        repeat ($urandom_range(0, 2))
          cyc(1'b0, ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)));
        cyc(1'b1, (use_sof && i == 0), 8'($urandom_range(0, 255)));
      end
    end
    drain("rand_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_window_3x3_gen

// File: doc/window_3x3_gen.md
# window_3x3_gen

Streaming 3x3 neighbourhood generator placed directly upstream of the 8-bit absolute-difference units in the edge-preserving noise-reduction datapath. It accepts one raster-order pixel per valid cycle, buffers the two previous lines, and presents a complete 3x3 window whose centre and eight neighbours feed the `|centre - neighbour|` subtractors. Windows are emitted only where all nine pixels lie inside the image; there is no border padding.

## Interface
- `IMG_WIDTH`, default 640: active pixels per line, ≥ 3.
- `DATA_W`, default 8: pixel width; the downstream subtractors require 8.
- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pix_in`  in  DATA_W  input pixel, raster order.
- `pix_valid`  in  1  `pix_in` is consumed this cycle.
- `sof`  in  1  qualified by `pix_valid`; the pixel is (row 0, col 0) of a new frame.
- `win`  out  9*DATA_W  packed window.
  - Index k = 3*dy + dx, with dy and dx in 0..2 and dy=0 the oldest line.
  - Pixel k occupies `win[DATA_W*k +: DATA_W]`; the centre is k=4.
- `win_valid`  out  1  `win` holds a complete in-image window this cycle.

## Operation
- Counters, advancing only on `pix_valid`:
  - `col` runs 0..IMG_WIDTH-1 and wraps to 0.
  - `row` increments on each `col` wrap and saturates at 2; only row ≥ 2 matters.
- `sof` with `pix_valid` forces the current pixel to (0,0) regardless of counter state. Counters then continue from (0,1).
- Line buffers:
  - Two buffers, each IMG_WIDTH deep, in a cascade: `lb0` holds the previous line and `lb1` the line before it.
  - On each `pix_valid` at column c:
    - read `lb1[c]`, giving the top tap, and `lb0[c]`, giving the middle tap;
    - write `lb1[c] <= lb0[c]` and `lb0[c] <= pix_in`.
  - The read returns the old contents (read-before-write).
- Window shift register, 3x3 of DATA_W bits:
  - On `pix_valid`, each row shifts left by one column.
  - New right column is (dx=2): top tap, middle tap, `pix_in`.
  - It holds its value when `pix_valid` is low.
- Validity:
  - `win_valid` is registered and equals (`pix_valid` AND row ≥ 2 AND col ≥ 2), evaluated for the pixel just accepted.
  - It is low in any cycle without `pix_valid`.
  - For the pixel accepted at (r,c), `win` spans rows r-2..r and columns c-2..c, centred on (r-1,c-1).
- There is no backpressure. Downstream must consume `win` in the cycle `win_valid` is high.
- Buffer contents are not reset. Stale data never reaches the output because of the row/col gating.
- A frame shorter than 3 lines produces no windows. A partial last line is simply abandoned at the next `sof`.

## Timing
- Latency: 1 cycle from the accepting `pix_valid` edge to `win`/`win_valid`.
- Throughput: 1 window per valid pixel. Stalls of any length, including mid-line, are transparent.
- Reset (`rst_n` low, at any time, including mid-frame):
  - `win` = 0, `win_valid` = 0, `col` = 0, `row` = 0, shift register cleared.
  - After release, the first pixel is treated as (0,0) even without `sof`.
- Simultaneous events:
  - `sof` on the wrap cycle: `sof` wins and the pixel is (0,0).
  - `sof` without `pix_valid` is ignored.
- Line buffer RAM: synchronous read with 1-cycle latency is permitted, provided the taps are aligned internally and the 1-cycle external latency above is preserved.

## Structure
- Shared package `nr_pkg`:
  - `PIX_W = 8`.
  - Window index constants `WIN_C = 4` and `WIN_N = 9`.
  - Neighbour index list {0,1,2,3,5,6,7,8} used by the abs-diff array.
- Sub-module `line_buffer`:
  - Parameters DEPTH and WIDTH.
  - One read/write address, read-before-write, no reset on storage.
  - Instantiated twice.
- Top level holds the counters, the shift register and the valid logic.

## Test plan
All tests use IMG_WIDTH=4 and pixel value = 16*row + col.
- 4x4 frame, `sof` on the first pixel, continuous valid:
  - exactly 4 `win_valid` pulses, 1 cycle after pixels (2,2), (2,3), (3,2), (3,3);
  - the first window is {00,01,02,10,11,12,20,21,22}, centre 0x11.
- Same frame with `pix_valid` low on every other cycle, plus a 5-cycle gap at the end of row 1:
  - identical `win` sequence;
  - `win_valid` never high in a stalled cycle.
- Two back-to-back frames with the second `sof` arriving after only 2 of row 3's pixels:
  - the second frame's first window appears after its pixel (2,2) and equals the first window of the first frame;
  - no window mixes data from the two frames.
- `rst_n` pulsed low asynchronously, between clock edges, mid-row 2:
  - `win` and `win_valid` go to 0 immediately;
  - a fresh 4x4 frame without `sof` yields the same 4 windows as the first test.
- `sof` asserted with `pix_valid` low → no counter change.
  - Then `sof` on the column-wrap cycle → that pixel is (0,0), and no window is emitted for the following 9 pixels.
